d5m_axis_packer: RTL and testbench

D5M_AXIS_PACKER -- requirements
Module: d5m_axis_packer

---
 rtl/d5m_axis_packer.sv | 152 +++++++++++++++
 tb/tb_d5m_axis_packer.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d5m_axis_packer.sv
// D5M camera to AXI4-Stream packer: frame/line tracking, one-pixel hold stage and
// an output FIFO that drops pixels (never stalls the camera) when full.
module d5m_axis_packer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  pixclk,
    input  logic                  reset,
    input  logic                  ifval,
    input  logic                  ilval,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic                  rgb_m_axis_tready,
    output logic                  rgb_m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] rgb_m_axis_tdata,
    output logic                  rgb_m_axis_tuser,
    output logic                  rgb_m_axis_tlast,
    input  logic                  ovf_clr,
    output logic                  overflow,
    output logic [15:0]           drop_count,
    output logic [15:0]           frame_count,
    output logic [11:0]           line_width,
    output logic [11:0]           frame_lines
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam int          EW         = DATA_WIDTH + 2;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {SYNC, IDLE, FRAME} state_t;

    state_t                  state;
    logic                    hold_valid;
    logic [DATA_WIDTH-1:0]   hold_data;
    logic                    sof_pending;
    logic [11:0]             px_cnt;
    logic [11:0]             line_cnt;

    logic [EW-1:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;

    logic                    capture;
    logic                    push;
    logic                    pop;
    logic                    accept;
    logic                    drop;
    logic [EW-1:0]           wr_entry;
    logic [EW-1:0]           rd_entry;

    // The held pixel is pushed every cycle it exists; it closes the line when
    // no new pixel replaces it.
    always_comb begin
        capture           = (state == FRAME) && ifval && ilval;
        push              = hold_valid;
        rgb_m_axis_tvalid = (count != '0);
        pop               = rgb_m_axis_tvalid && rgb_m_axis_tready;
        accept            = push && ((count != FULL_COUNT) || pop);
        drop              = push && !accept;
        wr_entry          = {sof_pending, !capture, hold_data};
        rd_entry          = mem[rd_ptr];
        rgb_m_axis_tdata  = rgb_m_axis_tvalid ? rd_entry[DATA_WIDTH-1:0] : '0;
        rgb_m_axis_tuser  = rgb_m_axis_tvalid && rd_entry[EW-1];
        rgb_m_axis_tlast  = rgb_m_axis_tvalid && rd_entry[EW-2];
    end

    // NOTE: FIFO storage has no reset; the pointers and count define what is valid.
    always_ff @(posedge pixclk) begin
        if (accept) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            state       <= SYNC;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            sof_pending <= 1'b0;
            px_cnt      <= '0;
            line_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
            frame_count <= '0;
            line_width  <= '0;
            frame_lines <= '0;
        end else begin
            hold_valid <= capture;
            if (capture) begin
                hold_data <= idata;
                px_cnt    <= !hold_valid ? 12'd1 :
                             (px_cnt == 12'hFFF) ? px_cnt : px_cnt + 12'd1;
            end
            if (capture && !hold_valid && (line_cnt != 12'hFFF)) begin
                line_cnt <= line_cnt + 12'd1;
            end
            if (push && !capture) begin
                line_width <= px_cnt;
            end
            if (accept) begin
                sof_pending <= 1'b0;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Clearing takes priority over a drop in the same cycle.
            if (ovf_clr) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end

            case (state)
                SYNC: begin
                    if (!ifval) state <= IDLE;
                end
                IDLE: begin
                    if (ifval) begin
                        state       <= FRAME;
                        sof_pending <= 1'b1;
                        line_cnt    <= '0;
                    end
                end
                FRAME: begin
                    if (!ifval) begin
                        state       <= IDLE;
                        frame_lines <= line_cnt;
                        frame_count <= frame_count + 16'd1;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_d5m_axis_packer.sv
// Directed self-checking bench for d5m_axis_packer: beats are collected on the
// falling edge and compared against hand-computed expected sequences.
module tb_d5m_axis_packer;

    localparam int DW = 24;
    localparam int BW = DW + 2;

    logic          pixclk = 1'b0;
    logic          reset;
    logic          ifval;
    logic          ilval;
    logic [DW-1:0] idata;
    logic          tready;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tuser;
    logic          tlast;
    logic          ovf_clr;
    logic          overflow;
    logic [15:0]   drop_count;
    logic [15:0]   frame_count;
    logic [11:0]   line_width;
    logic [11:0]   frame_lines;

    int checks = 0;
    int errors = 0;
    bit toggle_ready = 1'b0;

    logic [BW-1:0] got[$];
    int            stall_viol = 0;
    logic          was_stalled = 1'b0;
    logic [BW-1:0] stall_beat = '0;

    d5m_axis_packer #(.DATA_WIDTH(DW), .FIFO_DEPTH(16)) dut (
        .pixclk            (pixclk),
        .reset             (reset),
        .ifval             (ifval),
        .ilval             (ilval),
        .idata             (idata),
        .rgb_m_axis_tready (tready),
        .rgb_m_axis_tvalid (tvalid),
        .rgb_m_axis_tdata  (tdata),
        .rgb_m_axis_tuser  (tuser),
        .rgb_m_axis_tlast  (tlast),
        .ovf_clr           (ovf_clr),
        .overflow          (overflow),
        .drop_count        (drop_count),
        .frame_count       (frame_count),
        .line_width        (line_width),
        .frame_lines       (frame_lines)
    );

    always #5 pixclk = ~pixclk;

    // Beat capture and stall-stability tracking, sampled mid-cycle.
    always @(negedge pixclk) begin
        if (tvalid && tready) got.push_back({tuser, tlast, tdata});
        if (was_stalled && tvalid && ({tuser, tlast, tdata} !== stall_beat)) stall_viol++;
        was_stalled = tvalid && !tready && !reset;
        stall_beat  = {tuser, tlast, tdata};
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic step();
        @(posedge pixclk);
        #1;
        if (toggle_ready) tready = ~tready;
    endtask

    task automatic apply_reset();
        reset = 1'b1; ifval = 1'b0; ilval = 1'b0; idata = '0;
        tready = 1'b0; ovf_clr = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic run_frame(input int lines, input int pix, input int first);
        ifval = 1'b1;
        step();
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < pix; p++) begin
                ilval = 1'b1;
                idata = DW'(first + l * pix + p);
                step();
            end
            ilval = 1'b0;
            idata = '0;
            step(); step();
        end
        ifval = 1'b0;
        step(); step();
    endtask

    task automatic drain();
        int n = 0;
        tready = 1'b1;
        while (tvalid && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (tvalid !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout tvalid=%0b after %0d cycles, want 0", tvalid, n);
        end
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({tvalid, tuser, tlast, tdata} !== '0) begin
            errors++;
            $display("FAIL reset_stream got v=%b u=%b l=%b d=%h want all 0", tvalid, tuser, tlast, tdata);
        end
        checks++;
        if ({overflow, drop_count, frame_count, line_width, frame_lines} !== '0) begin
            errors++;
            $display("FAIL reset_status got ovf=%b drop=%0d fc=%0d lw=%0d fl=%0d want 0",
                     overflow, drop_count, frame_count, line_width, frame_lines);
        end
    endtask

    task automatic test_basic();
        int base;
        logic [BW-1:0] exp;
        base = got.size();
        tready = 1'b1;
        run_frame(2, 4, 1);
        drain();
        checks++;
        if (got.size() - base != 8) begin
            errors++;
            $display("FAIL basic_count got %0d want 8", got.size() - base);
        end
        for (int i = 0; i < 8; i++) begin
            exp = {i == 0, (i % 4) == 3, DW'(i + 1)};
            checks++;
            if (base + i >= got.size() || got[base + i] !== exp) begin
                errors++;
                $display("FAIL basic_beat%0d got %h want %h", i,
                         (base + i < got.size()) ? got[base + i] : '0, exp);
            end
        end
        checks++;
        if ({line_width, frame_lines, frame_count} !== {12'd4, 12'd2, 16'd1}) begin
            errors++;
            $display("FAIL basic_status got lw=%0d fl=%0d fc=%0d want 4 2 1",
                     line_width, frame_lines, frame_count);
        end
    endtask

    task automatic test_single_pixel();
        int base;
        base = got.size();
        tready = 1'b0;
        ifval = 1'b1;
        step();
        ilval = 1'b1;
        idata = 24'hABCDEF;
        step();
        checks++;
        if (tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_hold tvalid=%b want 0", tvalid);
        end
        ilval = 1'b0;
        idata = '0;
        step();
        checks++;
        if ({tvalid, tuser, tlast, tdata} !== {3'b111, 24'hABCDEF}) begin
            errors++;
            $display("FAIL single_beat got v=%b u=%b l=%b d=%h want 1 1 1 abcdef",
                     tvalid, tuser, tlast, tdata);
        end
        checks++;
        if (line_width !== 12'd1) begin
            errors++;
            $display("FAIL single_width got %0d want 1", line_width);
        end
        ifval = 1'b0;
        step(); step();
        checks++;
        if ({frame_lines, frame_count} !== {12'd1, 16'd2}) begin
            errors++;
            $display("FAIL single_frame got fl=%0d fc=%0d want 1 2", frame_lines, frame_count);
        end
        drain();
        checks++;
        if (got.size() - base != 1) begin
            errors++;
            $display("FAIL single_count got %0d want 1", got.size() - base);
        end
    endtask

    task automatic test_sync();
        int base;
        logic [BW-1:0] exp;
        reset = 1'b1; ifval = 1'b1; ilval = 1'b1; idata = 24'h99; tready = 1'b1;
        step(); step();
        base = got.size();
        reset = 1'b0;
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 4; p++) begin
                ilval = 1'b1;
                idata = DW'(8'h90 + p);
                step();
            end
            ilval = 1'b0;
            step(); step();
        end
        checks++;
        if (tvalid !== 1'b0 || got.size() != base) begin
            errors++;
            $display("FAIL sync_discard got tvalid=%b beats=%0d want 0 0", tvalid, got.size() - base);
        end
        ifval = 1'b0;
        step(); step();
        checks++;
        if (frame_count !== 16'd0) begin
            errors++;
            $display("FAIL sync_frame_count got %0d want 0", frame_count);
        end
        run_frame(1, 3, 'h30);
        drain();
        checks++;
        if (got.size() - base != 3) begin
            errors++;
            $display("FAIL sync_count got %0d want 3", got.size() - base);
        end
        for (int i = 0; i < 3; i++) begin
            exp = {i == 0, i == 2, DW'('h30 + i)};
            checks++;
            if (base + i >= got.size() || got[base + i] !== exp) begin
                errors++;
                $display("FAIL sync_beat%0d got %h want %h", i,
                         (base + i < got.size()) ? got[base + i] : '0, exp);
            end
        end
        checks++;
        if ({frame_count, line_width, frame_lines} !== {16'd1, 12'd3, 12'd1}) begin
            errors++;
            $display("FAIL sync_status got fc=%0d lw=%0d fl=%0d want 1 3 1",
                     frame_count, line_width, frame_lines);
        end
    endtask

    task automatic test_overflow();
        int base;
        logic [BW-1:0] exp;
        apply_reset();
        base = got.size();
        tready = 1'b0;
        ifval = 1'b1;
        step();
        for (int p = 0; p < 20; p++) begin
            ilval = 1'b1;
            idata = DW'('h100 + p);
            step();
        end
        ilval = 1'b0;
        step(); step();
        ifval = 1'b0;
        step(); step();
        checks++;
        if ({overflow, drop_count, line_width} !== {1'b1, 16'd4, 12'd20}) begin
            errors++;
            $display("FAIL ovf_status got ovf=%b drop=%0d lw=%0d want 1 4 20",
                     overflow, drop_count, line_width);
        end
        drain();
        checks++;
        if (got.size() - base != 16) begin
            errors++;
            $display("FAIL ovf_count got %0d want 16", got.size() - base);
        end
        for (int i = 0; i < 16; i++) begin
            exp = {i == 0, 1'b0, DW'('h100 + i)};
            checks++;
            if (base + i >= got.size() || got[base + i] !== exp) begin
                errors++;
                $display("FAIL ovf_beat%0d got %h want %h", i,
                         (base + i < got.size()) ? got[base + i] : '0, exp);
            end
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++;
        if ({overflow, drop_count} !== {1'b0, 16'd0}) begin
            errors++;
            $display("FAIL ovf_clear got ovf=%b drop=%0d want 0 0", overflow, drop_count);
        end

        // Second frame: clear coincides with the drop of the line's last pixel.
        base = got.size();
        tready = 1'b0;
        ifval = 1'b1;
        step();
        for (int p = 0; p < 20; p++) begin
            ilval = 1'b1;
            idata = DW'('h200 + p);
            step();
        end
        ilval = 1'b0;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++;
        if ({overflow, drop_count} !== {1'b0, 16'd0}) begin
            errors++;
            $display("FAIL ovf_clr_race got ovf=%b drop=%0d want 0 0", overflow, drop_count);
        end
        ifval = 1'b0;
        step(); step();
        drain();
        checks++;
        if (got.size() - base != 16) begin
            errors++;
            $display("FAIL ovf_race_count got %0d want 16", got.size() - base);
        end
    endtask

    task automatic test_backpressure();
        int base;
        int sv;
        logic [BW-1:0] exp;
        apply_reset();
        base = got.size();
        sv = stall_viol;
        tready = 1'b1;
        toggle_ready = 1'b1;
        run_frame(4, 4, 'h61);
        toggle_ready = 1'b0;
        drain();
        checks++;
        if (got.size() - base != 16) begin
            errors++;
            $display("FAIL bp_count got %0d want 16", got.size() - base);
        end
        for (int i = 0; i < 16; i++) begin
            exp = {i == 0, (i % 4) == 3, DW'('h61 + i)};
            checks++;
            if (base + i >= got.size() || got[base + i] !== exp) begin
                errors++;
                $display("FAIL bp_beat%0d got %h want %h", i,
                         (base + i < got.size()) ? got[base + i] : '0, exp);
            end
        end
        checks++;
        if (stall_viol != sv) begin
            errors++;
            $display("FAIL bp_stable got %0d changes while stalled want 0", stall_viol - sv);
        end
        checks++;
        if ({overflow, drop_count} !== {1'b0, 16'd0}) begin
            errors++;
            $display("FAIL bp_drops got ovf=%b drop=%0d want 0 0", overflow, drop_count);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        logic [BW-1:0] exp;
        apply_reset();
        tready = 1'b0;
        ifval = 1'b1;
        step();
        ilval = 1'b1;
        idata = 24'h41;
        step();
        idata = 24'h42;
        step();
        checks++;
        if (tvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre tvalid=%b want 1", tvalid);
        end
        reset = 1'b1;
        idata = 24'h43;
        step();
        checks++;
        if (tvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset tvalid=%b want 0", tvalid);
        end
        reset = 1'b0;
        ilval = 1'b0;
        ifval = 1'b0;
        step(); step();
        base = got.size();
        tready = 1'b1;
        run_frame(2, 4, 'h51);
        drain();
        checks++;
        if (got.size() - base != 8) begin
            errors++;
            $display("FAIL mid_count got %0d want 8", got.size() - base);
        end
        for (int i = 0; i < 8; i++) begin
            exp = {i == 0, (i % 4) == 3, DW'('h51 + i)};
            checks++;
            if (base + i >= got.size() || got[base + i] !== exp) begin
                errors++;
                $display("FAIL mid_beat%0d got %h want %h", i,
                         (base + i < got.size()) ? got[base + i] : '0, exp);
            end
        end
        checks++;
        if (frame_count !== 16'd1) begin
            errors++;
            $display("FAIL mid_frame_count got %0d want 1", frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_pixel();
        test_sync();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
